// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : div_pkg                                                 |
// | Brief    : Shared types and saturation helpers for the div_rv      |
// |            iterative signed fixed-point divider.                   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package div_pkg;

  // Rounding modes; RM_RSV behaves as round-half-to-even.
  typedef enum logic [1:0] {
    RM_TRUNC = 2'd0,
    RM_EVEN  = 2'd1,
    RM_AWAY  = 2'd2,
    RM_RSV   = 2'd3
  } rmode_t;

  // Controller states, in the order an operation walks through them.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CALC  = 3'd2,
    S_ROUND = 3'd3,
    S_SIGN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Largest positive two's-complement value of a w-bit word (0111...1).
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word (100...0).
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_round.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : div_round                                               |
// | Brief    : Combinational rounding, overflow detection and sign     |
// |            application for an unsigned quotient magnitude.        |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module div_round
  import div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FBITS = 4,
  parameter int SAT   = 1
) (
  input  logic [WIDTH+FBITS-1:0] i_q,
  input  logic                   i_r,
  input  logic                   i_s,
  input  rmode_t                 i_rmode,
  input  logic                   i_neg,
  output logic [WIDTH-1:0]       o_val,
  output logic                   o_ovf
);

  // One extra bit so that rounding up the largest quotient cannot wrap.
  localparam int               c_qw  = WIDTH + FBITS + 1;
  localparam logic [WIDTH-1:0] c_max = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] c_min = WIDTH'(sat_min(WIDTH));

  logic             w_inc;
  logic [c_qw-1:0]  w_mag;
  logic [c_qw-1:0]  w_lim;
  logic [WIDTH-1:0] w_clamp;

  // Decide whether the magnitude is bumped by one LSB.
  always_comb begin
    w_inc = 1'b0;
    case (i_rmode)
      RM_TRUNC: w_inc = 1'b0;
      RM_AWAY:  w_inc = i_r;
      default:  w_inc = i_r & (i_s | i_q[0]);
    endcase
  end

  // Apply the increment, test against the signed range, then apply the sign.
  always_comb begin
    w_mag   = {1'b0, i_q} + c_qw'(w_inc);
    // A negative result may reach one LSB further than a positive one.
    w_lim   = i_neg ? c_qw'(c_min) : c_qw'(c_max);
    w_clamp = (SAT != 0) ? (i_neg ? c_min : c_max) : '0;
    o_ovf   = (w_mag > w_lim);
    if (o_ovf) begin
      o_val = w_clamp;
    end else if (i_neg) begin
      // Negating a zero magnitude yields +0, so no special case is needed.
      o_val = -w_mag[WIDTH-1:0];
    end else begin
      o_val = w_mag[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_rv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : div_rv                                                  |
// | Brief    : Iterative signed fixed-point divider (restoring), with  |
// |            valid/ready on both sides, rounding modes, overflow     |
// |            policy and a pass-through tag.                          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module div_rv
  import div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FBITS = 4,
  parameter int TAGW  = 4,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       rmode,
  input  logic [TAGW-1:0]  tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val,
  output logic [TAGW-1:0]  out_tag,
  output logic             dbz,
  output logic             ovf,
  output logic             busy
);

  localparam int               c_iter = WIDTH + FBITS;
  localparam int               c_cw   = $clog2(c_iter + 1);
  localparam logic [c_cw-1:0]  c_last = c_cw'(c_iter - 1);
  localparam logic [WIDTH-1:0] c_max  = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] c_min  = WIDTH'(sat_min(WIDTH));

  state_t            r_state;
  state_t            w_next;

  // Operation context latched on the accept edge.
  logic [WIDTH-1:0]  r_bmag;
  logic              r_neg;
  logic              r_asign;
  logic              r_zdiv;
  rmode_t            r_rmode;
  logic [TAGW-1:0]   r_tag;

  // Divider datapath: partial remainder, quotient shift register, step count.
  logic [WIDTH-1:0]  r_acc;
  logic [c_iter-1:0] r_q;
  logic [c_cw-1:0]   r_cnt;
  logic              r_r;

  // Result registers held through DONE.
  logic [WIDTH-1:0]  r_val;
  logic              r_dbz;
  logic              r_ovf;
  logic              r_busy;

  logic              w_accept;
  logic [WIDTH-1:0]  w_amag;
  logic [WIDTH-1:0]  w_bmag;
  logic [WIDTH:0]    w_shift;
  logic [WIDTH-1:0]  w_diff;
  logic              w_ge;
  logic [WIDTH-1:0]  w_rem;
  logic              w_sticky;
  logic [WIDTH-1:0]  w_rval;
  logic              w_rovf;
  logic [WIDTH-1:0]  w_dbz_val;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  // Magnitudes are unsigned WIDTH-bit, so the most negative input maps to 2^(WIDTH-1).
  assign w_amag    = a[WIDTH-1] ? -a : a;
  assign w_bmag    = b[WIDTH-1] ? -b : b;

  assign w_sticky  = (r_acc != '0);
  assign w_dbz_val = (SAT != 0) ? (r_asign ? c_min : c_max) : '0;

  assign val       = r_val;
  assign out_tag   = r_tag;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

  // One restoring step: CALC shifts in the next dividend bit, ROUND shifts in a zero.
  always_comb begin
    w_shift = {r_acc, (r_state == S_CALC) ? r_q[c_iter-1] : 1'b0};
    w_ge    = (w_shift >= {1'b0, r_bmag});
    // When the subtraction succeeds the true difference is below |b| and fits WIDTH bits.
    w_diff  = w_shift[WIDTH-1:0] - r_bmag;
    w_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
  end

  div_round #(
    .WIDTH (WIDTH),
    .FBITS (FBITS),
    .SAT   (SAT)
  ) u_round (
    .i_q     (r_q),
    .i_r     (r_r),
    .i_s     (w_sticky),
    .i_rmode (r_rmode),
    .i_neg   (r_neg),
    .o_val   (w_rval),
    .o_ovf   (w_rovf)
  );

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. A zero divisor skips the datapath and lands in DONE one edge after accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_INIT;
      S_INIT:  w_next = r_zdiv ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == c_last) w_next = S_ROUND;
      S_ROUND: w_next = S_SIGN;
      S_SIGN:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operation capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bmag  <= '0;
      r_neg   <= 1'b0;
      r_asign <= 1'b0;
      r_zdiv  <= 1'b0;
      r_rmode <= RM_TRUNC;
      r_tag   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_r     <= 1'b0;
      r_val   <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bmag  <= w_bmag;
            r_q     <= c_iter'(w_amag);
            r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
            r_asign <= a[WIDTH-1];
            r_zdiv  <= (b == '0);
            r_rmode <= rmode_t'(rmode);
            r_tag   <= tag;
            r_busy  <= 1'b1;
          end
        end
        S_INIT: begin
          r_acc <= '0;
          // Pre-scale the dividend so the integer quotient carries FBITS fraction bits.
          r_q   <= r_q << FBITS;
          r_cnt <= '0;
          if (r_zdiv) begin
            r_val  <= w_dbz_val;
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc <= w_rem;
          r_q   <= {r_q[c_iter-2:0], w_ge};
          r_cnt <= r_cnt + c_cw'(1);
        end
        S_ROUND: begin
          // The guard iteration yields the round bit; its remainder becomes the sticky source.
          r_r   <= w_ge;
          r_acc <= w_rem;
        end
        S_SIGN: begin
          r_val  <= w_rval;
          r_ovf  <= w_rovf;
          r_dbz  <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_rv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_div_rv                                               |
// | Brief    : Self-checking bench for div_rv (SAT=1 and SAT=0 copies  |
// |            run in lockstep) against an arithmetic reference model. |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_div_rv;

  localparam int W    = 16;
  localparam int FB   = 4;
  localparam int TW   = 4;
  localparam int ITER = W + FB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    rmode = '0;
  logic [TW-1:0] tag = '0;

  logic          in_ready, out_valid, dbz, ovf, busy;
  logic [W-1:0]  val;
  logic [TW-1:0] out_tag;
  logic          in_ready0, out_valid0, dbz0, ovf0, busy0;
  logic [W-1:0]  val0;
  logic [TW-1:0] out_tag0;

  int            n_tests = 0;
  int            n_fail  = 0;

  logic [W-1:0]  last_val, last_val0;
  logic          last_dbz, last_ovf, last_ovf0;
  logic [TW-1:0] last_tag;
  int            last_lat;

  always #5 clk = ~clk;

  div_rv #(.WIDTH(W), .FBITS(FB), .TAGW(TW), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rmode(rmode), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .val(val), .out_tag(out_tag),
    .dbz(dbz), .ovf(ovf), .busy(busy)
  );

  div_rv #(.WIDTH(W), .FBITS(FB), .TAGW(TW), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .rmode(rmode), .tag(tag),
    .out_valid(out_valid0), .out_ready(out_ready), .val(val0), .out_tag(out_tag0),
    .dbz(dbz0), .ovf(ovf0), .busy(busy0)
  );

  // Reference: exact rational quotient |a|*2^FB/|b|, rounded by mode, then range-checked.
  function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic [1:0] rm, input bit sat,
                                output logic [W-1:0] ev, output logic edbz, output logic eovf);
    longint sa, sb, num, den, q, rem, inc, mag, lim, maxv, minv;
    bit neg;
    sa   = longint'($signed(ia));
    sb   = longint'($signed(ib));
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = longint'(1) <<< (W - 1);
    edbz = (sb == 0);
    eovf = 1'b0;
    if (edbz) begin
      ev = !sat ? '0 : (sa < 0 ? W'(minv) : W'(maxv));
    end else begin
      num = (sa < 0 ? -sa : sa) * (longint'(1) <<< FB);
      den = (sb < 0 ? -sb : sb);
      q   = num / den;
      rem = num % den;
      case (rm)
        2'd0:    inc = 0;
        2'd2:    inc = (2 * rem >= den) ? 1 : 0;
        default: inc = ((2 * rem > den) || ((2 * rem == den) && (q % 2 == 1))) ? 1 : 0;
      endcase
      mag = q + inc;
      neg = (sa < 0) != (sb < 0);
      lim = neg ? minv : maxv;
      if (mag > lim) begin
        eovf = 1'b1;
        ev   = !sat ? '0 : (neg ? W'(minv) : W'(maxv));
      end else begin
        ev = W'(neg ? -mag : mag);
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Issue one operation, wait for the result, check it, optionally hold off the consumer.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] irm,
                       input logic [TW-1:0] itg, input int hold);
    logic [W-1:0] ev1, ev0;
    logic         ed, eo1, eo0;
    int           edges;
    model(ia, ib, irm, 1'b1, ev1, ed, eo1);
    model(ia, ib, irm, 1'b0, ev0, ed, eo0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    a = ia; b = ib; rmode = irm; tag = itg; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); rmode = 2'($urandom); tag = TW'($urandom);
    chk("busy_rise", 32'(busy), 32'd1);
    chk("in_ready_low", 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", 32'(edges), ed ? 32'd1 : 32'(ITER + 3));
    last_val = val; last_val0 = val0; last_dbz = dbz;
    last_ovf = ovf; last_ovf0 = ovf0; last_tag = out_tag; last_lat = edges;
    if (out_valid) begin
      chk("val_sat1", 32'(val), 32'(ev1));
      chk("val_sat0", 32'(val0), 32'(ev0));
      chk("dbz", 32'({dbz, dbz0}), 32'({ed, ed}));
      chk("ovf_sat1", 32'(ovf), 32'(eo1));
      chk("ovf_sat0", 32'(ovf0), 32'(eo0));
      chk("out_tag", 32'(out_tag), 32'(itg));
      chk("busy_fall", 32'({busy, busy0}), 32'd0);
      chk("valid_sat0", 32'(out_valid0), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_val", 32'(val), 32'(ev1));
      chk("bp_tag", 32'(out_tag), 32'(itg));
      chk("bp_flags", 32'({dbz, ovf}), 32'({ed, eo1}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_fall", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", 32'({out_valid, busy, dbz, ovf}), 32'd0);
    chk("rst_val", 32'(val), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic division 7.0 / 2.0
    do_op(16'h0070, 16'h0020, 2'd0, 4'd5, 0);
    chk("s1_val", 32'(last_val), 32'h0038);
    chk("s1_tag", 32'(last_tag), 32'd5);
    chk("s1_lat", 32'(last_lat), 32'd23);
    chk("s1_flags", 32'({last_dbz, last_ovf}), 32'd0);

    // Rounding at half and one-and-a-half LSB
    do_op(16'h0001, 16'h0020, 2'd0, 4'd1, 0); chk("s2_a_rm0", 32'(last_val), 32'h0000);
    do_op(16'h0001, 16'h0020, 2'd1, 4'd1, 0); chk("s2_a_rm1", 32'(last_val), 32'h0000);
    do_op(16'h0001, 16'h0020, 2'd2, 4'd1, 0); chk("s2_a_rm2", 32'(last_val), 32'h0001);
    do_op(16'h0003, 16'h0020, 2'd0, 4'd2, 0); chk("s2_b_rm0", 32'(last_val), 32'h0001);
    do_op(16'h0003, 16'h0020, 2'd1, 4'd2, 0); chk("s2_b_rm1", 32'(last_val), 32'h0002);
    do_op(16'h0003, 16'h0020, 2'd2, 4'd2, 0); chk("s2_b_rm2", 32'(last_val), 32'h0002);
    do_op(16'hFFFD, 16'h0020, 2'd0, 4'd3, 0); chk("s2_c_rm0", 32'(last_val), 32'hFFFF);
    do_op(16'hFFFD, 16'h0020, 2'd2, 4'd3, 0); chk("s2_c_rm2", 32'(last_val), 32'hFFFE);

    // Full-range input and overflow (both overflow policies)
    do_op(16'h8000, 16'h0010, 2'd0, 4'd4, 0);
    chk("s3_min_val", 32'(last_val), 32'h8000);
    chk("s3_min_ovf", 32'(last_ovf), 32'd0);
    do_op(16'h8000, 16'hFFF0, 2'd0, 4'd4, 0);
    chk("s3_ovf_val", 32'(last_val), 32'h7FFF);
    chk("s3_ovf_flag", 32'(last_ovf), 32'd1);
    chk("s3_sat0_val", 32'(last_val0), 32'h0000);
    chk("s3_sat0_ovf", 32'(last_ovf0), 32'd1);

    // Divide by zero
    do_op(16'h0050, 16'h0000, 2'd0, 4'd6, 0);
    chk("s4_lat", 32'(last_lat), 32'd1);
    chk("s4_dbz", 32'(last_dbz), 32'd1);
    chk("s4_pos_val", 32'(last_val), 32'h7FFF);
    do_op(16'hFF00, 16'h0000, 2'd1, 4'd7, 0);
    chk("s4_neg_val", 32'(last_val), 32'h8000);

    // Randomized operations with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 16'h8000;
        1:       ra = 16'h7FFF;
        2:       ra = '0;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 16'h8000;
        2, 3:    rb = W'($urandom_range(1, 64));
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) rb = -rb;
      do_op(ra, rb, 2'($urandom), TW'($urandom), 0);
    end

    // Backpressure: consumer holds off for five cycles
    do_op(16'h0070, 16'h0020, 2'd1, 4'd9, 5);
    chk("s5_val", 32'(last_val), 32'h0038);

    // Reset ten iterations into CALC
    a = 16'h0070; b = 16'h0020; rmode = 2'd0; tag = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_in_ready", 32'(in_ready), 32'd1);
    chk("s6_outs", 32'({out_valid, busy, dbz, ovf}), 32'd0);
    chk("s6_val", 32'(val), 32'd0);
    chk("s6_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(16'h0070, 16'h0020, 2'd0, 4'd5, 0);
    chk("s6_rep_val", 32'(last_val), 32'h0038);
    chk("s6_rep_lat", 32'(last_lat), 32'd23);
    chk("s6_rep_tag", 32'(last_tag), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
